hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Time-multiplexing scan controller for the board's seven-segment hex displays. It holds one 4-bit value and one enable bit per digit position, and walks the positions round-robin through a single shared hex-to-segment decoder. For each position it drives the decoded segments and an active-low digit select, with a blanking gap between positions to prevent ghosting. It sits between the notepad's character/status logic, which writes digit values, and the display pins.

## Interface
- `NUM_DIGITS`, 4: number of scanned digit positions (2..8).
- `PRESCALE`, 50000: clock cycles per digit slot (ON plus GAP).
- `GAP`, 500: blanked cycles at the start of each slot; 1 ≤ `GAP` < `PRESCALE`.
- `clock`  in  1  system clock; all state rises on its positive edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; low blanks the display and parks the scan.
- `wr_en`  in  1  write strobe, one cycle per write.
- `wr_addr`  in  3  target digit position.
- `wr_data`  in  4  hex value to store.
- `wr_show`  in  1  enable bit stored with the value (0 means blank that digit).
- `SEG`  out  7  segments {g..a}, active-low.
- `DIG_N`  out  NUM_DIGITS  digit selects, one-hot active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Register file: `NUM_DIGITS` × {value[3:0], show}. A write with `wr_en=1` and `wr_addr < NUM_DIGITS` updates the entry on the next edge. A write with `wr_addr ≥ NUM_DIGITS` is ignored. Writes are accepted in every state, including while `en=0`.
- FSM states:
  - GAP: all digits off. Lasts `GAP` cycles, then goes to ON.
  - ON: selected digit driven. Lasts `PRESCALE-GAP` cycles, then goes to GAP.
- Slot counter: `$clog2(PRESCALE)` bits. Cleared on every state change.
- Digit index:
  - Advances at ON→GAP and wraps from `NUM_DIGITS-1` to 0.
  - `frame_tick` pulses on the cycle the index wraps.
- Snapshot: at GAP→ON, the entry for the current index is latched into a display register. Writes to the digit currently being shown do not change it until its next slot. A simultaneous write and snapshot to the same entry snapshots the old value.
- Decoding: the snapshot value passes through the shared decoder. Values 0–F map to the standard glyphs 0123456789AbCdEF.
- Blanking: during GAP, when `en=0`, or when the snapshot has `show=0`, the outputs are `SEG=7'h7F` and `DIG_N` all ones.
- Enable:
  - `en=0` forces GAP, clears the counter and index, and suppresses `frame_tick`.
  - When `en` rises, a full GAP runs before digit 0.

## Timing
- Reset values: `SEG=7'h7F`, `DIG_N` all ones, `frame_tick=0`, state GAP, counter 0, index 0, every register entry {0, show=0}.
- Reset is asynchronous in both directions of effect: asserting it mid-slot blanks the outputs immediately and discards the scan position. Register contents are also cleared.
- `SEG`, `DIG_N` and `frame_tick` are registered and lag the internal state by one cycle. Example: the cycle after GAP→ON, `DIG_N[idx]` goes low.
- Frame period is `NUM_DIGITS*PRESCALE` cycles. Each digit is lit for `PRESCALE-GAP` consecutive cycles per frame.
- Write-to-display latency is at most one frame plus one cycle.
- No output glitches between registered updates. `DIG_N` never has more than one bit low.

## Structure
- Shared package holds:
  - the segment encoding constants (`SEG_BLANK=7'h7F` and the 16 glyphs);
  - the FSM state enum {GAP, ON};
  - the `wr_addr` width constant (3).
- Sub-module: the existing `hex_display` combinational decoder, instantiated once and fed by the snapshot value.
- The wrapper owns the FSM, counter, index, register file and output registers.

## Test plan
All scenarios use `NUM_DIGITS=4`, `PRESCALE=8`, `GAP=2`.
- **Reset:** hold `resetn=0` for 3 cycles, then release with `en=0` → `SEG=7F`, `DIG_N=4'hF` and `frame_tick=0` throughout, with no activity.
- **Basic scan:** write digits 0..3 = {1,2,3,4}, all `show=1`, then set `en=1` → the sequence is 2 blank cycles, then `DIG_N=4'hE` with `SEG=79` for 6 cycles. Digits 1/2/3 follow with `SEG`=24/30/19. `frame_tick` pulses once every 32 cycles.
- **Mid-slot write:** while digit 2 is lit showing 3, write digit 2 = F → `SEG` stays 30 for the rest of the slot and reads 0E on digit 2's next slot.
- **Blank and range:** write digit 1 with `show=0`, then write to `wr_addr=5` → digit 1's slot is fully blank, and no register changes from the out-of-range write.
- **Enable drop:** drop `en` during digit 3's ON phase → blank on the next registered output. When `en` is raised again, the scan restarts with 2 GAP cycles and then digit 0.
- **Reset mid-slot:** assert `resetn` during digit 1's ON phase → `SEG=7F` and `DIG_N=F` immediately (asynchronously). After release, the digits are blank until they are rewritten.

Source files
------------

// File: rtl/hex_scan_ctrl_pkg.sv
// Shared constants and types for the hex display scan controller:
// active-low segment glyphs, scan FSM states and register-file entry layout.
package hex_scan_ctrl_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned HEX_W     = 4;
    localparam int unsigned WR_ADDR_W = 3;

    // Segments are {g,f,e,d,c,b,a}, a zero lights the segment.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;

    typedef enum logic {
        S_GAP = 1'b0,
        S_ON  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [HEX_W-1:0] value;
        logic             show;
    } digit_entry_t;

endpackage

// File: rtl/hex_scan_ctrl_hex.sv
// Combinational hex-to-seven-segment decoder (glyphs 0123456789AbCdEF).
module hex_display
    import hex_scan_ctrl_pkg::*;
(
    input  logic [HEX_W-1:0] hex_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (hex_i)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Round-robin scan of NUM_DIGITS seven-segment positions through one shared
// decoder, with a blanked gap at the start of every digit slot.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned GAP        = 500
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [WR_ADDR_W-1:0]  wr_addr,
    input  logic [HEX_W-1:0]      wr_data,
    input  logic                  wr_show,
    output logic [SEG_W-1:0]      SEG,
    output logic [NUM_DIGITS-1:0] DIG_N,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W  = $clog2(PRESCALE);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned ON_LEN = PRESCALE - GAP;

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    digit_entry_t          snap_q, snap_d;
    digit_entry_t          regs_q [NUM_DIGITS];
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
    logic                  tick_q, tick_d;
    logic [SEG_W-1:0]      seg_c;
    logic                  lit;
    logic                  wr_hit;

    hex_display u_dec (
        .hex_i (snap_q.value),
        .seg_c (seg_c)
    );

    // Register file: out-of-range addresses are dropped, writes accepted in any state.
    assign wr_hit = wr_en && (32'(wr_addr) < NUM_DIGITS);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit) begin
            regs_q[wr_addr[IDX_W-1:0]] <= '{value: wr_data, show: wr_show};
        end
    end

    // Scan state, slot counter, digit index, snapshot and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_GAP;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_BLANK;
            dig_n_q <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_n_q <= dig_n_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic; the snapshot reads regs_q, so a same-cycle write is not seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = S_GAP;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        snap_d  = regs_q[idx_q];
                    end
                end
                S_ON: begin
                    if (cnt_q == CNT_W'(ON_LEN - 1)) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign lit     = en && (state_q == S_ON) && snap_q.show;
    assign seg_d   = lit ? seg_c : SEG_BLANK;
    assign dig_n_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;

    assign SEG        = seg_q;
    assign DIG_N      = dig_n_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with a slot-arithmetic reference model
// checked every cycle, plus literal glyph/select expectations at key points.
module tb_hex_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int G     = 2;
    localparam int FRAME = N * P;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_show;
    logic [6:0] seg;
    logic [3:0] dig_n;
    logic       ft;

    int n_checks = 0;
    int n_errors = 0;
    int sc       = 0;

    hex_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GAP(G)) dut (
        .clock      (clk),
        .resetn     (resetn),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_show    (wr_show),
        .SEG        (seg),
        .DIG_N      (dig_n),
        .frame_tick (ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // s_m counts enabled edges since the scan was last parked; the slot phase
    // of the internal state is s_m mod FRAME and outputs trail it by one edge.
    int         s_m;
    logic [3:0] mem_v [N];
    logic       mem_s [N];
    logic [3:0] snap_v;
    logic       snap_s;
    logic [6:0] exp_seg;
    logic [3:0] exp_dig;
    logic       exp_ft;

    function automatic bit phase_lit(input int ph);
        return (ph % P) >= G;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_m     <= 0;
            snap_v  <= '0;
            snap_s  <= 1'b0;
            exp_seg <= 7'h7F;
            exp_dig <= 4'hF;
            exp_ft  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_v[i] <= '0;
                mem_s[i] <= 1'b0;
            end
        end else begin
            if (!en) begin
                s_m     <= 0;
                exp_seg <= 7'h7F;
                exp_dig <= 4'hF;
                exp_ft  <= 1'b0;
            end else begin
                s_m     <= s_m + 1;
                exp_seg <= (phase_lit(s_m % FRAME) && snap_s) ? glyph(snap_v) : 7'h7F;
                exp_dig <= (phase_lit(s_m % FRAME) && snap_s) ?
                           ~(4'(4'b0001 << ((s_m % FRAME) / P))) : 4'hF;
                exp_ft  <= ((s_m + 1) % FRAME) == 0;
                if (((s_m + 1) % FRAME) % P == G) begin
                    snap_v <= mem_v[((s_m + 1) % FRAME) / P];
                    snap_s <= mem_s[((s_m + 1) % FRAME) / P];
                end
            end
            if (wr_en && wr_addr < 3'(N)) begin
                mem_v[wr_addr[1:0]] <= wr_data;
                mem_s[wr_addr[1:0]] <= wr_show;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_seg", 8'(seg), 8'(exp_seg));
        check("model_dig_n", 8'(dig_n), 8'(exp_dig));
        check("model_frame_tick", 8'(ft), 8'(exp_ft));
        if (!$onehot0(~dig_n)) check("dig_n_onehot", 8'(dig_n), 8'hFF);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        sc += n;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_show = s;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic lit_check(input string name, input logic [6:0] s, input logic [3:0] d);
        check({name, "_seg"}, 8'(seg), 8'(s));
        check({name, "_dig_n"}, 8'(dig_n), 8'(d));
    endtask

    initial begin
        resetn  = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_show = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        lit_check("reset", 7'h7F, 4'hF);
        check("reset_frame_tick", 8'(ft), 8'h00);

        wr(3'd0, 4'h1, 1'b1);
        wr(3'd1, 4'h2, 1'b1);
        wr(3'd2, 4'h3, 1'b1);
        wr(3'd3, 4'h4, 1'b1);

        // Basic scan
        en = 1'b1;
        sc = 0;
        step(2);  lit_check("gap_before_d0", 7'h7F, 4'hF);
        step(1);  lit_check("d0_lit", 7'h79, 4'hE);
        step(8);  lit_check("d1_lit", 7'h24, 4'hD);
        step(8);  lit_check("d2_lit", 7'h30, 4'hB);
        step(8);  lit_check("d3_lit", 7'h19, 4'h7);
        step(5);  check("frame_tick_pulse", 8'(ft), 8'h01);
        step(1);  check("frame_tick_single", 8'(ft), 8'h00);

        // Mid-slot write to the digit being shown
        step(19);
        wr(3'd2, 4'hF, 1'b1);
        step(3);  lit_check("d2_held_old", 7'h30, 4'hB);
        step(27); lit_check("d2_new_value", 7'h0E, 4'hB);

        // Blank digit and out-of-range write (5 would alias digit 1 if truncated)
        wr(3'd1, 4'h0, 1'b0);
        wr(3'd5, 4'h9, 1'b1);
        step(22); lit_check("d1_blank", 7'h7F, 4'hF);

        // Enable drop during digit 3
        step(16); lit_check("d3_before_drop", 7'h19, 4'h7);
        step(1);
        en = 1'b0;
        step(1);  lit_check("en_drop_blank", 7'h7F, 4'hF);
        step(5);
        en = 1'b1;
        sc = 0;
        step(2);  lit_check("restart_gap", 7'h7F, 4'hF);
        step(1);  lit_check("restart_d0", 7'h79, 4'hE);

        // Asynchronous reset while digit 1 is lit
        wr(3'd1, 4'h6, 1'b1);
        step(8);  lit_check("d1_before_reset", 7'h02, 4'hD);
        #2 resetn = 1'b0;
        #1 lit_check("async_reset", 7'h7F, 4'hF);
        check("async_reset_tick", 8'(ft), 8'h00);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sc = 0;
        step(3);  lit_check("post_reset_d0", 7'h7F, 4'hF);
        step(8);  lit_check("post_reset_d1", 7'h7F, 4'hF);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
